// File: rtl/ifc_pkg.sv
// Shared definitions for the instruction fetch controller: FSM state
// encoding, opcode field positions and the decode bit indices used by
// both the controller and the branch unit.
package ifc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } ifc_state_t;

    // Opcode occupies IR[15:9]
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 9;

    // Opcode value that halts the controller when the halt option is built in
    localparam logic [6:0] HALT_OPC = 7'h7F;

    // Bit indices inside the 7-bit opcode
    localparam int PL_HI_BIT = 6;
    localparam int PL_LO_BIT = 5;
    localparam int JB_BIT    = 4;
    localparam int BC_BIT    = 0;

    function automatic logic [6:0] get_opcode(input logic [15:0] ir);
        return ir[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/branch_unit.sv
// Combinational next-PC computation: jump to the A-bus value, take a
// flag-conditional PC-relative branch, or fall through to PC + 1.
// All arithmetic wraps modulo 2^PC_W.
module branch_unit
    import ifc_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic [PC_W-1:0] i_pc,
    input  logic [15:0]     i_ir,
    input  logic            i_z,
    input  logic            i_n,
    input  logic [PC_W-1:0] i_jump_addr,
    output logic [PC_W-1:0] o_next_pc
);

    logic [6:0]      w_opcode;
    logic            w_pl;
    logic            w_jb;
    logic            w_bc;
    logic            w_taken;
    logic [5:0]      w_offset6;
    logic [PC_W-1:0] w_offset;
    logic            w_unused_ir_bits;

    assign w_opcode  = get_opcode(i_ir);
    assign w_pl      = w_opcode[PL_HI_BIT] & w_opcode[PL_LO_BIT];
    assign w_jb      = w_opcode[JB_BIT];
    assign w_bc      = w_opcode[BC_BIT];
    assign w_taken   = w_bc ? i_n : i_z;

    // Branch displacement is split across IR[8:6] and IR[2:0], signed
    assign w_offset6 = {i_ir[8:6], i_ir[2:0]};
    assign w_offset  = {{(PC_W-6){w_offset6[5]}}, w_offset6};

    // Opcode bits 3:1 and the SB field IR[5:3] do not affect sequencing
    assign w_unused_ir_bits = ^{w_opcode[3:1], i_ir[5:3]};

    // Select the next program counter
    always_comb begin
        o_next_pc = i_pc + PC_W'(1);
        if (w_pl && w_jb) begin
            o_next_pc = i_jump_addr;
        end else if (w_pl && w_taken) begin
            o_next_pc = i_pc + w_offset;
        end
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, fetches 16-bit words over a
// req/ack port, latches IR and strobes ExecEn for one cycle per instruction.
// Optional halt instruction is built in when IFC_HALT_EN is defined.
//
// Memory handshake: IMemReq is high for the whole FETCH state with IMemAddr
// held at PC; the cycle on which IMemAck is high transfers IMemData into IR.
// Acks arriving in any other state are ignored.
module instr_fetch_ctrl
    import ifc_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            CLK,
    input  logic            RST_N,
    output logic [PC_W-1:0] IMemAddr,
    output logic            IMemReq,
    input  logic            IMemAck,
    input  logic [15:0]     IMemData,
    output logic [15:0]     IR,
    output logic [7:0]      ConstantIn,
    output logic            ExecEn,
    input  logic [PC_W-1:0] JumpAddr,
    input  logic            Z,
    input  logic            N,
    output logic [PC_W-1:0] PC,
    output logic            Halted,
    output logic [1:0]      DbgState
);

    ifc_state_t      r_state;
    ifc_state_t      w_next_state;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_ir;
    logic [PC_W-1:0] w_next_pc;
    logic            w_is_halt;

`ifdef IFC_HALT_EN
    assign w_is_halt = (get_opcode(r_ir) == HALT_OPC);
`else
    assign w_is_halt = 1'b0;
`endif

    branch_unit #(
        .PC_W (PC_W)
    ) u_branch_unit (
        .i_pc        (r_pc),
        .i_ir        (r_ir),
        .i_z         (Z),
        .i_n         (N),
        .i_jump_addr (JumpAddr),
        .o_next_pc   (w_next_pc)
    );

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        w_next_state = r_state;
        IMemReq      = 1'b0;
        ExecEn       = 1'b0;
        Halted       = 1'b0;
        case (r_state)
            IDLE: begin
                w_next_state = FETCH;
            end
            FETCH: begin
                IMemReq = 1'b1;
                if (IMemAck) begin
                    w_next_state = EXEC;
                end
            end
            EXEC: begin
                if (w_is_halt) begin
                    w_next_state = HALT;
                end else begin
                    ExecEn       = 1'b1;
                    w_next_state = FETCH;
                end
            end
            HALT: begin
`ifdef IFC_HALT_EN
                Halted = 1'b1;
`endif
                w_next_state = HALT;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Program counter advances at the end of every executed instruction
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pc <= RESET_PC;
        end else if (r_state == EXEC && !w_is_halt) begin
            r_pc <= w_next_pc;
        end
    end

    // Instruction register captures the word on the acknowledged fetch cycle
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ir <= '0;
        end else if (r_state == FETCH && IMemAck) begin
            r_ir <= IMemData;
        end
    end

    assign IMemAddr   = r_pc;
    assign PC         = r_pc;
    assign IR         = r_ir;
    assign ConstantIn = {5'b00000, r_ir[2:0]};
    assign DbgState   = r_state;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed sequencing, branch,
// jump, wrap, reset and halt cases followed by randomized instruction
// streams with random memory latency. Halt expectations follow IFC_HALT_EN.
module tb_instr_fetch_ctrl;

    localparam int PC_W = 8;

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic [PC_W-1:0] IMemAddr;
    logic            IMemReq;
    logic            IMemAck = 1'b0;
    logic [15:0]     IMemData = '0;
    logic [15:0]     IR;
    logic [7:0]      ConstantIn;
    logic            ExecEn;
    logic [PC_W-1:0] JumpAddr = '0;
    logic            Z = 1'b0;
    logic            N = 1'b0;
    logic [PC_W-1:0] PC;
    logic            Halted;
    logic [1:0]      DbgState;

    int total = 0;
    int bad   = 0;

    // Scoreboard: expected fetch addresses, in order
    logic [7:0]  exp_q[$];
    logic [15:0] exp_ir = '0;

    instr_fetch_ctrl #(
        .PC_W     (PC_W),
        .RESET_PC (8'h00)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .IMemAddr   (IMemAddr),
        .IMemReq    (IMemReq),
        .IMemAck    (IMemAck),
        .IMemData   (IMemData),
        .IR         (IR),
        .ConstantIn (ConstantIn),
        .ExecEn     (ExecEn),
        .JumpAddr   (JumpAddr),
        .Z          (Z),
        .N          (N),
        .PC         (PC),
        .Halted     (Halted),
        .DbgState   (DbgState)
    );

    // Clock
    always #5 CLK = ~CLK;

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: next fetch address from the instruction rules, plain integer math
    function automatic logic [7:0] ref_next(input logic [7:0] pc, input logic [15:0] w,
                                            input logic z, input logic n, input logic [7:0] ja);
        int  off;
        int  p;
        bit  pl;
        bit  cond;
        p    = int'(pc);
        pl   = w[15] && w[14];
        cond = w[9] ? n : z;
        if (pl && w[13]) return ja;
        if (pl && cond) begin
            off = int'({w[8:6], w[2:0]});
            if (off >= 32) off = off - 64;
            return 8'((((p + off) % 256) + 256) % 256);
        end
        return 8'((p + 1) % 256);
    endfunction

    function automatic bit is_halt_word(input logic [15:0] w);
`ifdef IFC_HALT_EN
        return (w[15:9] == 7'h7F);
`else
        return (w[15:9] == 7'h00) && (w[15:9] != 7'h00);
`endif
    endfunction

    // Drive reset asynchronously between edges, check immediately, release
    task automatic do_reset();
        @(negedge CLK);
        #2;
        RST_N   = 1'b0;
        IMemAck = 1'b0;
        #1;
        check("rst_req", IMemReq, 0);
        check("rst_pc", PC, 0);
        check("rst_ir", IR, 0);
        check("rst_const", ConstantIn, 0);
        check("rst_exec", ExecEn, 0);
        check("rst_halted", Halted, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check("idle_req", IMemReq, 0);
        check("idle_exec", ExecEn, 0);
        exp_q.delete();
        exp_q.push_back(8'h00);
        exp_ir = '0;
    endtask

    // One instruction: fetch with dly wait cycles, then execute with given flags
    task automatic run_instr(input logic [15:0] w, input int dly, input logic z,
                             input logic n, input logic [7:0] ja);
        logic [7:0] addr;
        bit         h;
        h = is_halt_word(w);
        check("q_has_entry", 32'(exp_q.size() > 0), 1);
        addr = (exp_q.size() > 0) ? exp_q.pop_front() : PC;
        for (int i = 0; i <= dly; i++) begin
            @(negedge CLK);
            check("fetch_req", IMemReq, 1);
            check("fetch_addr", IMemAddr, addr);
            check("fetch_exec", ExecEn, 0);
            check("ir_hold", IR, exp_ir);
            IMemAck  = (i == dly);
            IMemData = (i == dly) ? w : 16'($urandom);
            Z        = 1'($urandom);
            N        = 1'($urandom);
            JumpAddr = 8'($urandom);
        end
        @(negedge CLK);
        check("exec_req", IMemReq, 0);
        check("exec_en", ExecEn, h ? 0 : 1);
        check("exec_ir", IR, w);
        check("exec_const", ConstantIn, {5'b0, w[2:0]});
        check("exec_pc", PC, addr);
        check("exec_halted", Halted, 0);
        IMemAck  = 1'b1;
        IMemData = 16'($urandom);
        Z        = z;
        N        = n;
        JumpAddr = ja;
        exp_ir   = w;
        if (!h) begin
            exp_q.push_back(ref_next(addr, w, z, n, ja));
        end else begin
            for (int k = 0; k < 4; k++) begin
                @(negedge CLK);
                check("halt_flag", Halted, 1);
                check("halt_req", IMemReq, 0);
                check("halt_exec", ExecEn, 0);
                check("halt_pc", PC, addr);
                check("halt_ir", IR, w);
                IMemAck  = 1'($urandom);
                IMemData = 16'($urandom);
            end
        end
    endtask

    initial begin
        logic [15:0] w;

        // Reset held, then released away from the clock edge
        repeat (2) @(negedge CLK);
        check("reset_pc", PC, 0);
        check("reset_req", IMemReq, 0);
        check("reset_ir", IR, 0);
        check("reset_exec", ExecEn, 0);
        check("reset_halted", Halted, 0);
        RST_N = 1'b1;
        #1;
        check("first_idle_req", IMemReq, 0);
        exp_q.push_back(8'h00);

        // Zero-wait sequential fetch of zero words: 0,1,2,3
        for (int i = 0; i < 4; i++) run_instr(16'h0000, 0, 1'b0, 1'b0, 8'h00);

        // Slow memory
        run_instr(16'h0003, 3, 1'b0, 1'b0, 8'h00);

        // Branch back by 2 from PC 10, taken and not taken
        run_instr(16'hE000, 0, 1'b0, 1'b0, 8'd10);
        run_instr(16'hC1C6, 1, 1'b1, 1'b0, 8'h00);
        run_instr(16'hE000, 0, 1'b0, 1'b0, 8'd10);
        run_instr(16'hC1C6, 0, 1'b0, 1'b1, 8'h00);

        // N-conditional forward branch by 5 from PC 20
        run_instr(16'hE000, 0, 1'b0, 1'b0, 8'd20);
        run_instr(16'hC205, 2, 1'b0, 1'b1, 8'h00);

        // Jump to C3, then wrap from 255 to 0
        run_instr(16'hE000, 0, 1'b0, 1'b0, 8'hC3);
        run_instr(16'hE000, 0, 1'b0, 1'b0, 8'hFF);
        run_instr(16'h0000, 0, 1'b1, 1'b1, 8'h00);

        // Backward branch wrapping below zero, then zero-offset re-fetch
        run_instr(16'hC1C6, 0, 1'b1, 1'b0, 8'h00);
        run_instr(16'hC000, 0, 1'b1, 1'b0, 8'h00);

        // All-ones opcode at PC 4 with JumpAddr 9
        run_instr(16'hE000, 0, 1'b0, 1'b0, 8'd4);
        run_instr(16'hFE00, 1, 1'b0, 1'b0, 8'd9);
        if (is_halt_word(16'hFE00)) do_reset();

        // Randomized instruction stream
        for (int i = 0; i < 80; i++) begin
            w = 16'($urandom);
            if (is_halt_word(w)) w[9] = 1'b0;
            run_instr(w, int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 8'($urandom));
        end

        // Reset asserted while a fetch is pending
        run_instr(16'hE000, 0, 1'b0, 1'b0, 8'h40);
        @(negedge CLK);
        check("midfetch_req", IMemReq, 1);
        check("midfetch_addr", IMemAddr, 8'h40);
        IMemAck = 1'b0;
        #2;
        RST_N = 1'b0;
        #1;
        check("async_req_drop", IMemReq, 0);
        check("async_pc", PC, 0);
        check("async_ir", IR, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check("restart_idle_req", IMemReq, 0);
        exp_q.delete();
        exp_q.push_back(8'h00);
        exp_ir = '0;
        run_instr(16'h0005, 0, 1'b0, 1'b0, 8'h00);
        run_instr(16'h0001, 2, 1'b0, 1'b0, 8'h00);

        // Final handful of random instructions including possible halt at end
        for (int i = 0; i < 10; i++) begin
            w = 16'($urandom);
            if (is_halt_word(w)) w[9] = 1'b0;
            run_instr(w, int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom), 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
